// File: rtl/usr_pkg.sv
// usr_pkg: shared mode and state encodings for the universal shift register.
package usr_pkg;
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    function automatic logic is_shift(input logic [2:0] mode);
        return mode inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR};
    endfunction
endpackage

// File: rtl/usr_step.sv
// usr_step: combinational next-value function shared by single-step and burst paths.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [2:0]       mode,
    input  logic             ser_in_sr,
    input  logic             ser_in_sl,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] nxt
);
    always_comb
        nxt = (mode == MODE_SHR)  ? {ser_in_sr, cur[WIDTH-1:1]} :
              (mode == MODE_SHL)  ? {cur[WIDTH-2:0], ser_in_sl} :
              (mode == MODE_LOAD) ? par_in :
              (mode == MODE_ROR)  ? {cur[0], cur[WIDTH-1:1]} :
              (mode == MODE_ROL)  ? {cur[WIDTH-2:0], cur[WIDTH-1]} :
              (mode == MODE_ASR)  ? {cur[WIDTH-1], cur[WIDTH-1:1]} :
              (mode == MODE_CLR)  ? '0 : cur;
endmodule

// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n: WIDTH-bit universal shift register with single-step ops and
// multi-cycle burst shifts under a busy/done handshake.
module univ_shift_reg_n
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_sr,
    input  logic             ser_in_sl,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, n_eff;
    logic [2:0]       op, step_mode;
    logic [WIDTH-1:0] reg_q, step_val;
    logic             burst_req, upd, done_nxt;

    assign n_eff     = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;
    assign burst_req = (state == ST_IDLE) && start && is_shift(mode);
    // The first shift of a burst uses the live mode; later ones the latched op.
    assign step_mode = (state == ST_RUN) ? op : mode;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .cur       (reg_q),
        .mode      (step_mode),
        .ser_in_sr (ser_in_sr),
        .ser_in_sl (ser_in_sl),
        .par_in    (par_in),
        .nxt       (step_val)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;

    always_comb
        state_nxt = (state == ST_RUN) ? ((cnt == CNT_W'(1)) ? ST_IDLE : ST_RUN)
                                      : ((burst_req && n_eff > CNT_W'(1)) ? ST_RUN : ST_IDLE);

    always_comb begin
        upd      = (state == ST_RUN) || (burst_req ? (n_eff != '0) : (start || en));
        cnt_nxt  = (state == ST_RUN) ? cnt - CNT_W'(1) :
                   (burst_req && n_eff != '0) ? n_eff - CNT_W'(1) : cnt;
        done_nxt = (state == ST_RUN) ? (cnt == CNT_W'(1)) : (burst_req && n_eff <= CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            reg_q <= '0;
            cnt   <= '0;
            op    <= MODE_HOLD;
            done  <= 1'b0;
        end else begin
            if (upd) reg_q <= step_val;
            if (burst_req) op <= mode;
            cnt  <= cnt_nxt;
            done <= done_nxt;
        end

    assign busy      = (state == ST_RUN);
    assign par_out   = reg_q;
    assign ser_out_r = reg_q[0];
    assign ser_out_l = reg_q[WIDTH-1];
endmodule

// File: tb/tb_univ_shift_reg_n.sv
// tb_univ_shift_reg_n: three widths driven by shared stimulus, each checked every
// cycle against a behavioural model, plus hand-computed WIDTH=8 expectations.
module tb_univ_shift_reg_n;
    localparam logic [2:0] HOLD = 3'd0, SHR = 3'd1, SHL = 3'd2, LOAD = 3'd3;
    localparam logic [2:0] ROR = 3'd4, ROL = 3'd5, ASR = 3'd6, CLR = 3'd7;

    logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, sr = 1'b0, sl = 1'b0, start = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [15:0] par_in = '0;
    logic [4:0]  shamt = '0;
    int          errors = 0, checks = 0;
    bit          cmp_on = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gw
        localparam int W  = (g == 0) ? 8 : (g == 1) ? 16 : 2;
        localparam int CW = $clog2(W + 1);
        logic [W-1:0] par_out, mq;
        logic         ser_out_r, ser_out_l, busy, done, mdone;
        logic [2:0]   mop;
        int           left, n;

        univ_shift_reg_n #(.WIDTH(W)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .mode      (mode),
            .ser_in_sr (sr),
            .ser_in_sl (sl),
            .par_in    (par_in[W-1:0]),
            .start     (start),
            .shamt     (shamt[CW-1:0]),
            .par_out   (par_out),
            .ser_out_r (ser_out_r),
            .ser_out_l (ser_out_l),
            .busy      (busy),
            .done      (done)
        );

        function automatic logic [W-1:0] f(input logic [W-1:0] q, input logic [2:0] m);
            case (m)
                SHR:     return (q >> 1) | (W'(sr) << (W - 1));
                SHL:     return (q << 1) | W'(sl);
                LOAD:    return par_in[W-1:0];
                ROR:     return (q >> 1) | (W'(q[0]) << (W - 1));
                ROL:     return (q << 1) | W'(q[W-1]);
                ASR:     return $unsigned($signed(q) >>> 1);
                CLR:     return '0;
                default: return q;
            endcase
        endfunction

        assign n = (int'(shamt[CW-1:0]) > W) ? W : int'(shamt[CW-1:0]);

        // Model: 'left' counts shifts still owed by a running burst.
        always @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                mq <= '0; left <= 0; mdone <= 1'b0; mop <= HOLD;
            end else if (left > 0) begin
                mq <= f(mq, mop); left <= left - 1; mdone <= (left == 1);
            end else if (start && mode inside {SHR, SHL, ROR, ROL, ASR}) begin
                mop <= mode; mdone <= (n <= 1); left <= (n > 0) ? n - 1 : 0;
                if (n > 0) mq <= f(mq, mode);
            end else begin
                mdone <= 1'b0;
                if (start || en) mq <= f(mq, mode);
            end

        always @(negedge clk)
            if (cmp_on && rst_n) begin
                chk($sformatf("w%0d par_out", W), par_out, mq);
                chk($sformatf("w%0d ser_out_r", W), ser_out_r, mq[0]);
                chk($sformatf("w%0d ser_out_l", W), ser_out_l, mq[W-1]);
                chk($sformatf("w%0d busy", W), busy, left > 0);
                chk($sformatf("w%0d done", W), done, mdone);
            end
    end

    task automatic drive(input logic e, input logic [2:0] m, input logic s_r, input logic s_l,
                         input logic [15:0] p, input logic st, input logic [4:0] sh);
        en = e; mode = m; sr = s_r; sl = s_l; par_in = p; start = st; shamt = sh;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, HOLD, 1'b0, 1'b0, 16'h0, 1'b0, 5'd0);
    endtask

    initial begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst par_out", gw[0].par_out, 16'h00);
        chk("rst busy", gw[0].busy, 16'h0);
        chk("rst done", gw[0].done, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        drive(1, LOAD, 0, 0, 16'h00B3, 0, 0);  chk("load", gw[0].par_out, 16'hB3);
        drive(1, SHR, 1, 0, 16'h0, 0, 0);      chk("shr", gw[0].par_out, 16'hD9);
        drive(1, SHL, 0, 0, 16'h0, 0, 0);      chk("shl", gw[0].par_out, 16'hB2);
        drive(1, ROR, 0, 0, 16'h0, 0, 0);      chk("ror", gw[0].par_out, 16'h59);
        drive(1, LOAD, 0, 0, 16'h0080, 0, 0);
        drive(1, ASR, 0, 0, 16'h0, 0, 0);      chk("asr", gw[0].par_out, 16'hC0);
        drive(1, CLR, 0, 0, 16'h0, 0, 0);      chk("clr", gw[0].par_out, 16'h00);
        drive(1, LOAD, 0, 0, 16'h005A, 0, 0);
        drive(0, LOAD, 0, 0, 16'h00FF, 0, 0);  chk("hold en0", gw[0].par_out, 16'h5A);
        drive(1, LOAD, 0, 0, 16'h0081, 0, 0);
        drive(0, ROL, 0, 0, 16'h0, 1, 3);      chk("burst e1", gw[0].par_out, 16'h03);
        chk("burst busy1", gw[0].busy, 16'h1);
        drive(1, CLR, 0, 0, 16'h0, 1, 0);      chk("burst e2", gw[0].par_out, 16'h06);
        chk("burst busy2", gw[0].busy, 16'h1);
        drive(0, SHL, 1, 1, 16'hFFFF, 0, 7);   chk("burst e3", gw[0].par_out, 16'h0C);
        chk("burst done", gw[0].done, 16'h1);
        chk("burst busy3", gw[0].busy, 16'h0);
        drive(0, SHR, 0, 0, 16'h0, 1, 2);      chk("b2b e1", gw[0].par_out, 16'h06);
        chk("b2b busy", gw[0].busy, 16'h1);
        idle();                                chk("b2b e2", gw[0].par_out, 16'h03);
        chk("b2b done", gw[0].done, 16'h1);
        idle();                                chk("done pulse", gw[0].done, 16'h0);
        drive(0, ROR, 0, 0, 16'h0, 1, 0);      chk("n0 par", gw[0].par_out, 16'h03);
        chk("n0 done", gw[0].done, 16'h1);
        chk("n0 busy", gw[0].busy, 16'h0);
        drive(0, SHL, 0, 1, 16'h0, 1, 1);      chk("n1 par", gw[0].par_out, 16'h07);
        chk("n1 done", gw[0].done, 16'h1);
        chk("n1 busy", gw[0].busy, 16'h0);
        drive(1, LOAD, 0, 0, 16'h00A5, 0, 0);
        drive(0, ROR, 0, 0, 16'h0, 1, 15);     chk("clamp e1", gw[0].par_out, 16'hD2);
        for (int i = 0; i < 6; i++) idle();
        chk("clamp busy7", gw[0].busy, 16'h1);
        idle();                                chk("clamp par", gw[0].par_out, 16'hA5);
        chk("clamp done", gw[0].done, 16'h1);
        drive(0, SHL, 0, 0, 16'h0, 1, 5);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst par", gw[0].par_out, 16'h00);
        chk("midrst busy", gw[0].busy, 16'h0);
        chk("midrst done", gw[0].done, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();                                chk("midrst no done", gw[0].done, 16'h0);
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom % 2), 3'($urandom % 8), 1'($urandom % 2), 1'($urandom % 2),
                  16'($urandom), ($urandom % 6) == 0, 5'($urandom % 17));
            if ($urandom % 400 == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
